// File: rtl/philv_dbg_pkg.sv
// Shared types and constants for the end-of-program register dump checker.
package philv_dbg_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    READ = 3'd1,
    CMP  = 3'd2,
    EMIT = 3'd3,
    DONE = 3'd4
  } state_e;

  localparam int NUM_ENTRIES = 38;
  localparam int EC_BASE_IDX = 32;
  localparam int IDX_W       = 6;

  localparam logic [IDX_W-1:0] ERR_MAX = 6'd63;

  // Error counter increment that sticks at the top of its range instead of wrapping.
  function automatic logic [IDX_W-1:0] sat_inc(input logic [IDX_W-1:0] val, input logic en);
    if (en && (val != ERR_MAX)) begin
      return val + 6'd1;
    end else begin
      return val;
    end
  endfunction

endpackage

// File: rtl/dump_idx_counter.sv
// Entry index for the dump walk: clear, increment and last-entry flag.
module dump_idx_counter
  import philv_dbg_pkg::*;
#(
  parameter int LAST_IDX = NUM_ENTRIES - 1
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             clr,
  input  logic             inc,
  output logic [IDX_W-1:0] idx,
  output logic [IDX_W-1:0] idx_nxt,
  output logic             last
);

  logic [IDX_W-1:0] idx_r;
  logic [IDX_W-1:0] idx_nxt_s;

  // Next index; idx_nxt is exported so the top can load read addresses in step.
  always_comb begin
    idx_nxt_s = idx_r;
    if (clr) begin
      idx_nxt_s = {IDX_W{1'b0}};
    end else if (inc) begin
      idx_nxt_s = idx_r + IDX_W'(1);
    end else begin
      idx_nxt_s = idx_r;
    end
  end

  // Index register.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      idx_r <= {IDX_W{1'b0}};
    end else begin
      idx_r <= idx_nxt_s;
    end
  end

  assign idx     = idx_r;
  assign idx_nxt = idx_nxt_s;
  assign last    = (idx_r == IDX_W'(LAST_IDX));

endmodule

// File: rtl/reg_file_dump_checker.sv
// Halt-triggered register file dump and compare against an expected-value memory.
// Define DUMP_STREAM_EN to stream each compare result out on the dump_* handshake.
module reg_file_dump_checker
  import philv_dbg_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int DATA_W  = 34,
  parameter int NUM_GPR = EC_BASE_IDX,
  parameter int NUM_EC  = NUM_ENTRIES - EC_BASE_IDX
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic [31:0]       instr,
  input  logic [31:0]       program_count,
  output logic [4:0]        gpr_rd_addr,
  input  logic [XLEN-1:0]   gpr_rd_data,
  output logic [2:0]        ec_rd_sel,
  input  logic [DATA_W-1:0] ec_rd_data,
  output logic [5:0]        exp_addr,
  input  logic [DATA_W-1:0] exp_data,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [5:0]        dump_idx,
  output logic [DATA_W-1:0] dump_actual,
  output logic [DATA_W-1:0] dump_expected,
  output logic              dump_mismatch,
  output logic              done,
  output logic [5:0]        error_count,
  output logic              pass
);

  localparam int LAST_IDX = NUM_GPR + NUM_EC - 1;

  state_e            state_r;
  state_e            state_nxt_s;
  logic              halt_s;
  logic              xfer_s;
  logic              is_ec_s;
  logic              mismatch_s;
  logic [DATA_W-1:0] actual_s;
  logic [IDX_W-1:0]  idx_s;
  logic [IDX_W-1:0]  idx_nxt_s;
  logic              last_s;
  logic              idx_clr_s;
  logic              idx_inc_s;
  logic [4:0]        gpr_rd_addr_r;
  logic [2:0]        ec_rd_sel_r;
  logic [5:0]        exp_addr_r;
  logic              done_r;
  logic              pass_r;
  logic [5:0]        err_r;

  assign halt_s     = (instr == 32'd0) && (program_count != 32'd0);
  assign is_ec_s    = (idx_s >= IDX_W'(NUM_GPR));
  assign actual_s   = is_ec_s ? ec_rd_data : {{(DATA_W-XLEN){1'b0}}, gpr_rd_data};
  assign mismatch_s = (actual_s != exp_data);

`ifdef DUMP_STREAM_EN
  assign xfer_s = dump_ready;
`else
  assign xfer_s = 1'b1;
`endif

  assign idx_clr_s = (state_r == IDLE);
  assign idx_inc_s = (state_r == EMIT) && xfer_s && !last_s;

  dump_idx_counter #(
    .LAST_IDX (LAST_IDX)
  ) u_idx (
    .clk     (clk),
    .rstb    (rstb),
    .clr     (idx_clr_s),
    .inc     (idx_inc_s),
    .idx     (idx_s),
    .idx_nxt (idx_nxt_s),
    .last    (last_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; DONE is terminal until reset.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (halt_s) begin
          state_nxt_s = READ;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      READ: state_nxt_s = CMP;
      CMP:  state_nxt_s = EMIT;
      EMIT: begin
        if (xfer_s) begin
          state_nxt_s = last_s ? DONE : READ;
        end else begin
          state_nxt_s = EMIT;
        end
      end
      DONE:    state_nxt_s = DONE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Read addresses are loaded on entry to READ so data returns during CMP; held otherwise.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      gpr_rd_addr_r <= 5'd0;
      ec_rd_sel_r   <= 3'd0;
      exp_addr_r    <= 6'd0;
    end else if (state_nxt_s == READ) begin
      exp_addr_r <= idx_nxt_s;
      if (idx_nxt_s < IDX_W'(NUM_GPR)) begin
        gpr_rd_addr_r <= idx_nxt_s[4:0];
      end else begin
        ec_rd_sel_r <= 3'(idx_nxt_s - IDX_W'(NUM_GPR));
      end
    end
  end

  // Mismatch count and completion status.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      err_r  <= 6'd0;
      done_r <= 1'b0;
      pass_r <= 1'b0;
    end else begin
      err_r  <= sat_inc(err_r, (state_r == CMP) && mismatch_s);
      done_r <= (state_nxt_s == DONE);
      pass_r <= (state_nxt_s == DONE) && (err_r == 6'd0);
    end
  end

  assign gpr_rd_addr = gpr_rd_addr_r;
  assign ec_rd_sel   = ec_rd_sel_r;
  assign exp_addr    = exp_addr_r;
  assign done        = done_r;
  assign error_count = err_r;
  assign pass        = pass_r;

`ifdef DUMP_STREAM_EN
  logic              dump_valid_r;
  logic [5:0]        dump_idx_r;
  logic [DATA_W-1:0] dump_actual_r;
  logic [DATA_W-1:0] dump_expected_r;
  logic              dump_mismatch_r;

  // Beat payload is captured in CMP and stays stable through any EMIT backpressure.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      dump_valid_r    <= 1'b0;
      dump_idx_r      <= 6'd0;
      dump_actual_r   <= {DATA_W{1'b0}};
      dump_expected_r <= {DATA_W{1'b0}};
      dump_mismatch_r <= 1'b0;
    end else begin
      dump_valid_r <= (state_nxt_s == EMIT);
      if (state_r == CMP) begin
        dump_idx_r      <= idx_s;
        dump_actual_r   <= actual_s;
        dump_expected_r <= exp_data;
        dump_mismatch_r <= mismatch_s;
      end
    end
  end

  assign dump_valid    = dump_valid_r;
  assign dump_idx      = dump_idx_r;
  assign dump_actual   = dump_actual_r;
  assign dump_expected = dump_expected_r;
  assign dump_mismatch = dump_mismatch_r;
`else
  logic unused_ready_s;

  assign unused_ready_s = dump_ready;
  assign dump_valid     = 1'b0;
  assign dump_idx       = 6'd0;
  assign dump_actual    = {DATA_W{1'b0}};
  assign dump_expected  = {DATA_W{1'b0}};
  assign dump_mismatch  = 1'b0;
`endif

endmodule

// File: tb/tb_reg_file_dump_checker.sv
// Directed bench for reg_file_dump_checker: vector table of dump runs plus reset/idle sequences.
`timescale 1ns/1ps
module tb_reg_file_dump_checker;

  localparam int N  = 38;
  localparam int NG = 32;

  logic        clk;
  logic        rstb;
  logic [31:0] instr;
  logic [31:0] program_count;
  logic [4:0]  gpr_rd_addr;
  logic [31:0] gpr_rd_data;
  logic [2:0]  ec_rd_sel;
  logic [33:0] ec_rd_data;
  logic [5:0]  exp_addr;
  logic [33:0] exp_data;
  logic        dump_valid;
  logic        dump_ready;
  logic [5:0]  dump_idx;
  logic [33:0] dump_actual;
  logic [33:0] dump_expected;
  logic        dump_mismatch;
  logic        done;
  logic [5:0]  error_count;
  logic        pass;

  logic [31:0] gpr_mem [32];
  logic [33:0] ec_mem  [8];
  logic [33:0] exp_mem [64];

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    int          cidx;
    logic [33:0] cact;
    logic [33:0] cexp;
    int          stall_idx;
    int          stall_len;
    bit          ready_idle;
    int          exp_err;
    bit          exp_pass;
  } vec_t;

  vec_t vecs [8];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  reg_file_dump_checker dut (
    .clk           (clk),
    .rstb          (rstb),
    .instr         (instr),
    .program_count (program_count),
    .gpr_rd_addr   (gpr_rd_addr),
    .gpr_rd_data   (gpr_rd_data),
    .ec_rd_sel     (ec_rd_sel),
    .ec_rd_data    (ec_rd_data),
    .exp_addr      (exp_addr),
    .exp_data      (exp_data),
    .dump_valid    (dump_valid),
    .dump_ready    (dump_ready),
    .dump_idx      (dump_idx),
    .dump_actual   (dump_actual),
    .dump_expected (dump_expected),
    .dump_mismatch (dump_mismatch),
    .done          (done),
    .error_count   (error_count),
    .pass          (pass)
  );

  // Register-file and expected-memory models with one-cycle registered reads.
  always @(posedge clk) begin
    gpr_rd_data <= gpr_mem[gpr_rd_addr];
    ec_rd_data  <= ec_mem[ec_rd_sel];
    exp_data    <= exp_mem[exp_addr];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [33:0] act_of(input int k);
    if (k < NG) return {2'b00, gpr_mem[k]};
    return ec_mem[k-NG];
  endfunction

  task automatic init_mems();
    for (int i = 0; i < 64; i++) exp_mem[i] = 34'd0;
    for (int i = 0; i < 8; i++) ec_mem[i] = 34'd0;
    for (int i = 0; i < NG; i++) begin
      gpr_mem[i] = 32'hA500_0000 + 32'(i) * 32'h0001_0101;
      exp_mem[i] = {2'b00, gpr_mem[i]};
    end
    for (int j = 0; j < 6; j++) begin
      ec_mem[j]       = {2'b10, 32'h5A00_0000 + 32'(j)};
      exp_mem[NG + j] = ec_mem[j];
    end
  endtask

  task automatic chk_zero_outs(input string name);
    chk(name, 64'({dump_valid, dump_idx, dump_mismatch, done, error_count, pass,
                   gpr_rd_addr, ec_rd_sel, exp_addr}), 64'd0);
    chk({name, "_payload"}, 64'(|{dump_actual, dump_expected}), 64'd0);
  endtask

  // Reset pulse away from clock edges; caller sets instr/pc beforehand.
  task automatic do_reset();
    @(negedge clk);
    rstb = 1'b0;
    #2;
    chk_zero_outs("reset_outs");
    @(negedge clk);
    rstb = 1'b1;
  endtask

  // Halt is presented before the next edge; c counts edges after the halt edge.
  task automatic run_dump(input string tag, input int stall_idx, input int stall_len,
                          input bit ready_idle, input int exp_err, input bit exp_pass);
    int          done_at;
    int          beats;
    int          addr_bad;
    int          beat_bad;
    int          valid_bad;
    int          stall_cnt;
    int          k;
    int          exp_done;
    logic [74:0] held;
    done_at   = -1;
    beats     = 0;
    addr_bad  = 0;
    beat_bad  = 0;
    valid_bad = 0;
    stall_cnt = 0;
    held      = '0;
    instr         = 32'd0;
    program_count = 32'h0000_0400;
    dump_ready    = ready_idle;
    for (int c = 0; c < 400 && done_at < 0; c++) begin
      tick();
`ifdef DUMP_STREAM_EN
      k = beats;
`else
      k = c / 3;
`endif
      if (k > N - 1) k = N - 1;
      if (exp_addr !== 6'(k)) addr_bad++;
      if (k < NG) begin
        if (gpr_rd_addr !== 5'(k)) addr_bad++;
      end else begin
        if (ec_rd_sel !== 3'(k - NG)) addr_bad++;
      end
`ifdef DUMP_STREAM_EN
      if (dump_valid === 1'b1) begin
        if (stall_cnt < stall_len && dump_idx == 6'(stall_idx)) begin
          if (stall_cnt == 0) held = {dump_idx, dump_actual, dump_expected, dump_mismatch};
          else if ({dump_idx, dump_actual, dump_expected, dump_mismatch} !== held) beat_bad++;
          stall_cnt++;
          dump_ready = 1'b0;
        end else begin
          if (beats >= N) beat_bad++;
          else if (dump_idx !== 6'(beats) || dump_actual !== act_of(beats) ||
                   dump_expected !== exp_mem[beats] ||
                   dump_mismatch !== (act_of(beats) != exp_mem[beats])) beat_bad++;
          beats++;
          dump_ready = 1'b1;
        end
      end
`else
      if (dump_valid !== 1'b0 || dump_mismatch !== 1'b0 || dump_idx !== 6'd0 ||
          (|{dump_actual, dump_expected}) !== 1'b0) valid_bad++;
`endif
      if (done === 1'b1) done_at = c;
    end
`ifdef DUMP_STREAM_EN
    exp_done = 114 + stall_len;
    chk({tag, "_beats"}, 64'(beats), 64'(N));
    chk({tag, "_beat_payload_bad"}, 64'(beat_bad), 64'd0);
`else
    exp_done = 114;
    chk({tag, "_dump_tied_bad"}, 64'(valid_bad), 64'd0);
`endif
    chk({tag, "_done_cycle"}, 64'(done_at), 64'(exp_done));
    chk({tag, "_addr_bad"}, 64'(addr_bad), 64'd0);
    chk({tag, "_error_count"}, 64'(error_count), 64'(exp_err));
    chk({tag, "_pass"}, 64'(pass), 64'(exp_pass));
  endtask

  initial begin
    int bad;
    bit reached;
    rstb          = 1'b0;
    instr         = 32'h0000_0013;
    program_count = 32'd0;
    dump_ready    = 1'b1;
    init_mems();

    vecs[0] = '{"clean", -1,  34'h0,           34'h0,           0, 0, 1'b1, 0, 1'b1};
    vecs[1] = '{"r05",   5,   34'h2,           34'h1,           0, 0, 1'b1, 1, 1'b0};
    vecs[2] = '{"ec2",   34,  34'h3_0000_0001, 34'h0,           0, 0, 1'b1, 1, 1'b0};
    vecs[3] = '{"first", 0,   34'h0,           34'h1,           0, 0, 1'b1, 1, 1'b0};
    vecs[4] = '{"last",  37,  34'h2_FFFF_FFFF, 34'h0_FFFF_FFFF, 0, 0, 1'b1, 1, 1'b0};
    vecs[5] = '{"zext",  31,  34'h0_FFFF_FFFF, 34'h3_FFFF_FFFF, 0, 0, 1'b1, 1, 1'b0};
    vecs[6] = '{"stall", -1,  34'h0,           34'h0,           3, 10, 1'b1, 0, 1'b1};
    vecs[7] = '{"rdy0",  10,  34'h7,           34'h8,           0, 0, 1'b0, 1, 1'b0};

    // Reset with pc == 0 and instr == 0 must never start a dump.
    instr         = 32'd0;
    program_count = 32'd0;
    do_reset();
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (done !== 1'b0 || dump_valid !== 1'b0 || exp_addr !== 6'd0 ||
          gpr_rd_addr !== 5'd0 || ec_rd_sel !== 3'd0 || error_count !== 6'd0) bad++;
    end
    chk("idle_pc0_bad", 64'(bad), 64'd0);

    for (int v = 0; v < 8; v++) begin
      init_mems();
      if (vecs[v].cidx >= 0) begin
        if (vecs[v].cidx < NG) gpr_mem[vecs[v].cidx] = vecs[v].cact[31:0];
        else ec_mem[vecs[v].cidx - NG] = vecs[v].cact;
        exp_mem[vecs[v].cidx] = vecs[v].cexp;
      end
      instr         = 32'h0000_0013;
      program_count = 32'd0;
      do_reset();
      run_dump(vecs[v].name, vecs[v].stall_idx, vecs[v].stall_len, vecs[v].ready_idle,
               vecs[v].exp_err, vecs[v].exp_pass);
    end

    // Later halts after DONE are ignored and state is held.
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      instr         = (i % 2 == 0) ? 32'd0 : 32'h0000_0013;
      program_count = 32'h0000_0800;
      tick();
      if (done !== 1'b1 || exp_addr !== 6'd37 || error_count !== 6'd1 || pass !== 1'b0) bad++;
    end
    chk("after_done_hold_bad", 64'(bad), 64'd0);

    // Reset in the middle of a dump, then restart from index 0 with halt held across reset release.
    init_mems();
    gpr_mem[7] = 32'h0000_0BAD;
    instr         = 32'h0000_0013;
    program_count = 32'd0;
    do_reset();
    instr         = 32'd0;
    program_count = 32'h0000_0400;
    dump_ready    = 1'b1;
    reached       = 1'b0;
    for (int c = 0; c < 200 && !reached; c++) begin
      tick();
      if (exp_addr == 6'd20) reached = 1'b1;
    end
    chk("reach_idx20", 64'(reached), 64'd1);
    #2;
    rstb = 1'b0;
    #1;
    chk_zero_outs("midreset_outs");
    @(negedge clk);
    rstb = 1'b1;
    run_dump("restart", 0, 0, 1'b1, 1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
